interconn_fifo: RTL and testbench
=================================

Name: interconn_fifo

Overview:
- Parametrised successor to the MVU crossbar interconnect.
- Each of N receivers selects one of N senders, as before, but transfers now use valid/ready handshakes.
- Each receiver has its own FIFO of depth D.
- A sender word is delivered atomically to every receiver currently subscribed to it (multicast), and backpressure from any subscriber stalls the sender.

Parameters:
- N, 8, number of MVU ports (senders = receivers = N).
- W, 128, word width in bits.
- D, 4, per-receiver FIFO depth; power of two, at least 2.
- A (local), max(1, $clog2(N)), width of one source address.
- L (local), $clog2(D+1), width of one occupancy count.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- clr_n, input, 1, asynchronous active-low reset.
- send_en, input, N, per-sender word valid.
- send_word, input, N*W, sender j's word in [j*W +: W].
- send_rdy, output, N, per-sender ready; transfer occurs when send_en[j] and send_rdy[j] are both 1.
- recv_from, input, N*A, receiver i's source address in [i*A +: A].
- recv_sub, input, N, receiver i subscription enable.
- recv_en, output, N, receiver FIFO non-empty (valid).
- recv_word, output, N*W, receiver i's head-of-FIFO word in [i*W +: W].
- recv_rdy, input, N, receiver pop; a pop occurs when recv_en[i] and recv_rdy[i] are both 1.
- recv_level, output, N*L, receiver i's FIFO occupancy, 0..D.

Behaviour:
- **Reset:** clr_n low asynchronously empties all FIFOs, clears pointers, forces recv_en=0, recv_word=0, recv_level=0. send_rdy follows the combinational rule below (all 1 after reset, since every FIFO is empty).
- **Subscription:** receiver i subscribes to sender j when recv_sub[i]=1 and recv_from[i]==j.
  - An address of N or greater means unsubscribed.
  - When N=1, recv_from is ignored and the address is treated as 0.
  - Subscription is evaluated combinationally each cycle. A change affects only future pushes; words already buffered stay queued.
- **send_rdy[j]** is the AND, over all receivers subscribed to j, of (level_i < D).
  - With no subscribers, send_rdy[j]=1 and an accepted word is discarded.
  - send_rdy depends only on registered levels, recv_from and recv_sub. There is no combinational path from recv_rdy or send_en to send_rdy.
- **Push:** on a transfer from sender j, send_word[j] is written into every subscribed receiver FIFO in the same edge. A partial multicast is never allowed.
- **Full FIFO:** a FIFO at level D blocks its sender even if that receiver pops in the same cycle. A full-FIFO push is therefore impossible by construction.
- **Latency:** a word accepted at edge k appears on recv_en/recv_word after edge k, i.e. one cycle of latency into an empty FIFO.
- **recv_word:** shows the FIFO head when recv_en=1 and is forced to 0 when recv_en=0.
- **Pop:** recv_rdy while empty has no effect.
- **Level update:** level' = level + push - pop.
  - Simultaneous push and pop at level 1..D-1 leaves the level unchanged and advances both pointers.
  - Push into an empty FIFO that is also being "popped" is a push only, because the pop is void when recv_en=0.
- **Pointers:** log2(D)-bit read/write pointers wrap modulo D. Level is held as a separate counter.
- **Independence:** each receiver is independent, and a single sender may feed any subset of receivers.
- **FIFO storage:** register array, no RAM macro, no bypass path.

Test Plan:
1. **Unicast:** N=8, reset, receiver 3 subscribes to sender 5. Send 0xA5 with send_en[5] for one cycle. Expect recv_en[3]=1 with recv_word=0xA5 the cycle after the accepting edge, and all other recv_en=0.
2. **Multicast:** receivers 0, 2 and 7 subscribe to sender 1; send word 0x11. Expect all three FIFOs at level 1 on the same cycle, each presenting 0x11.
3. **Backpressure:** D=4, receiver 0 on sender 2, recv_rdy[0]=0. Push 4 words; expect send_rdy[2]=0 once level=4. Assert recv_rdy[0] for one cycle; expect send_rdy[2]=1 on the next cycle, with the words read out in order.
4. **Multicast stall:** receivers 1 (full) and 4 (empty) both subscribe to sender 0. Expect send_rdy[0]=0 and no push to receiver 4 until receiver 1 pops.
5. **Concurrent push/pop, wrap and reselection:** stream 20 words into receiver 6 while holding recv_rdy[6]=1.
   - Expect level to stay at or below 1 and to stay constant while push and pop coincide.
   - Expect data order preserved across pointer wrap.
   - Switch recv_from[6] mid-stream: buffered words drain first.
6. **No subscriber, then async reset:** with no subscriber, send_en[3] gives send_rdy[3]=1 and the word is dropped, with every recv_level unchanged. Then pull clr_n low mid-cycle with FIFOs partly full. Expect recv_en=0, recv_word=0 and recv_level=0 immediately, with no clock edge.

Source files
------------

// File: rtl/interconn_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : interconn_fifo
//  Description : N x N valid/ready crossbar. Each receiver picks one sender
//                and buffers words in its own D-deep FIFO. A sender word is
//                multicast atomically to every subscribed receiver. Any full
//                subscriber stalls that sender.
//  Revision    : 1.0 - initial release
// ============================================================================
module interconn_fifo #(
    parameter  int N = 8,
    parameter  int W = 128,
    parameter  int D = 4,
    localparam int A = (N > 1) ? $clog2(N) : 1,
    localparam int L = $clog2(D + 1)
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic [N-1:0]   send_en,
    input  logic [N*W-1:0] send_word,
    output logic [N-1:0]   send_rdy,
    input  logic [N*A-1:0] recv_from,
    input  logic [N-1:0]   recv_sub,
    output logic [N-1:0]   recv_en,
    output logic [N*W-1:0] recv_word,
    input  logic [N-1:0]   recv_rdy,
    output logic [N*L-1:0] recv_level
);

    localparam int P = $clog2(D);

    // w_sub[i*N + j] is set when receiver i currently listens to sender j.
    logic [N*N-1:0] w_sub;
    // Per-receiver FIFO full flag, taken from registered levels only.
    logic [N-1:0]   w_full;
    logic [N-1:0]   w_send_rdy;
    logic [N-1:0]   w_xfer;
    logic [N-1:0]   w_push;
    logic [W-1:0]   w_din [N];

    genvar gi, gj;

    generate
        for (gi = 0; gi < N; gi++) begin : g_sub
            if (N == 1) begin : g_single
                // With one sender the address carries no information.
                assign w_sub[gi] = recv_sub[gi];
            end else begin : g_multi
                for (gj = 0; gj < N; gj++) begin : g_src
                    // Addresses >= N never match any sender, so they read as unsubscribed.
                    assign w_sub[gi*N + gj] = recv_sub[gi] &&
                                              (recv_from[gi*A +: A] == A'(gj));
                end
            end
        end
    endgenerate

    // Sender ready: every subscribed receiver must have room. A full FIFO blocks
    // even when it pops this cycle, which keeps recv_rdy out of this path.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_send_rdy[j] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (w_sub[i*N + j] && w_full[i]) begin
                    w_send_rdy[j] = 1'b0;
                end
            end
        end
    end

    assign send_rdy = w_send_rdy;
    assign w_xfer   = send_en & w_send_rdy;

    // Route each accepted sender word to its subscribers. A receiver has at most one source.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_push[i] = 1'b0;
            w_din[i]  = '0;
            for (int j = 0; j < N; j++) begin
                if (w_sub[i*N + j] && w_xfer[j]) begin
                    w_push[i] = 1'b1;
                    w_din[i]  = send_word[j*W +: W];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_fifo
            logic [W-1:0] r_mem [D];
            logic [P-1:0] r_wptr;
            logic [P-1:0] r_rptr;
            logic [L-1:0] r_level;
            logic         w_pop;
            logic         w_nonempty;

            assign w_nonempty = (r_level != '0);
            // A pop on an empty FIFO is void.
            assign w_pop      = recv_rdy[gi] && w_nonempty;
            assign w_full[gi] = (r_level == L'(D));

            // Pointer and occupancy bookkeeping; pointers wrap naturally since D is a power of two.
            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_level <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wptr <= r_wptr + P'(1);
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + P'(1);
                    end
                    case ({w_push[gi], w_pop})
                        2'b10:   r_level <= r_level + L'(1);
                        2'b01:   r_level <= r_level - L'(1);
                        default: r_level <= r_level;
                    endcase
                end
            end

            // Storage write; contents need no reset because the output is masked when empty.
            always_ff @(posedge clk) begin
                if (w_push[gi]) begin
                    r_mem[r_wptr] <= w_din[gi];
                end
            end

            assign recv_en[gi]              = w_nonempty;
            assign recv_word[gi*W +: W]     = w_nonempty ? r_mem[r_rptr] : '0;
            assign recv_level[gi*L +: L]    = r_level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_interconn_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interconn_fifo
//  Description : Directed self-checking bench for interconn_fifo with a
//                scoreboard of expected words per receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interconn_fifo;

    localparam int N = 8;
    localparam int W = 128;
    localparam int D = 4;
    localparam int A = 3;
    localparam int L = 3;

    logic           clk = 1'b0;
    logic           clr_n;
    logic [N-1:0]   send_en;
    logic [N*W-1:0] send_word;
    logic [N-1:0]   send_rdy;
    logic [N*A-1:0] recv_from;
    logic [N-1:0]   recv_sub;
    logic [N-1:0]   recv_en;
    logic [N*W-1:0] recv_word;
    logic [N-1:0]   recv_rdy;
    logic [N*L-1:0] recv_level;

    interconn_fifo #(.N(N), .W(W), .D(D)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .send_en    (send_en),
        .send_word  (send_word),
        .send_rdy   (send_rdy),
        .recv_from  (recv_from),
        .recv_sub   (recv_sub),
        .recv_en    (recv_en),
        .recv_word  (recv_word),
        .recv_rdy   (recv_rdy),
        .recv_level (recv_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           rx;
        logic [W-1:0] w;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic int cnt(int i);
        int c = 0;
        for (int k = 0; k < sb.size(); k++) if (sb[k].rx == i) c++;
        return c;
    endfunction

    function automatic logic [W-1:0] head(int i);
        for (int k = 0; k < sb.size(); k++) if (sb[k].rx == i) return sb[k].w;
        return '0;
    endfunction

    function automatic bit msub(int i, int j);
        return recv_sub[i] && (int'(recv_from[i*A +: A]) == j);
    endfunction

    function automatic bit mrdy(int j);
        for (int i = 0; i < N; i++) if (msub(i, j) && cnt(i) >= D) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sub(int i, int j);
        recv_from[i*A +: A] = A'(j);
        recv_sub[i]         = 1'b1;
    endtask

    task automatic send(int j, logic [W-1:0] w);
        send_en[j]          = 1'b1;
        send_word[j*W +: W] = w;
    endtask

    // One clock: check ready and popped data before the edge, update the model, check FIFO state after.
    task automatic cyc();
        exp_t pend[$];
        bit   pop_i [N];
        #1;
        for (int j = 0; j < N; j++) begin
            check($sformatf("send_rdy[%0d]", j), W'(send_rdy[j]), W'(mrdy(j)));
            if (send_en[j] && mrdy(j)) begin
                for (int i = 0; i < N; i++) begin
                    if (msub(i, j)) pend.push_back('{i, send_word[j*W +: W]});
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            pop_i[i] = recv_rdy[i] && (cnt(i) > 0);
            if (pop_i[i]) check($sformatf("pop_word[%0d]", i), recv_word[i*W +: W], head(i));
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (pop_i[i]) begin
                for (int k = 0; k < sb.size(); k++) begin
                    if (sb[k].rx == i) begin
                        sb.delete(k);
                        break;
                    end
                end
            end
        end
        foreach (pend[k]) sb.push_back(pend[k]);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("recv_level[%0d]", i), W'(recv_level[i*L +: L]), W'(cnt(i)));
            check($sformatf("recv_en[%0d]", i), W'(recv_en[i]), W'(cnt(i) > 0));
            check($sformatf("recv_word[%0d]", i), recv_word[i*W +: W], head(i));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100us");
        $fatal(1, "timeout");
    end

    initial begin
        clr_n     = 1'b0;
        send_en   = '0;
        send_word = '0;
        recv_from = '0;
        recv_sub  = '0;
        recv_rdy  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_recv_en",    W'(recv_en),    '0);
        check("rst_recv_level", W'(recv_level), '0);
        check("rst_recv_word",  recv_word[W-1:0], '0);
        check("rst_send_rdy",   W'(send_rdy),   W'({N{1'b1}}));
        clr_n = 1'b1;
        cyc();

        // Unicast: receiver 3 on sender 5
        sub(3, 5);
        send(5, 128'hA5);
        cyc();
        send_en = '0;
        check("t1_recv_en",   W'(recv_en), W'(8'b0000_1000));
        check("t1_recv_word", recv_word[3*W +: W], 128'hA5);
        recv_rdy[3] = 1'b1;
        cyc();
        recv_rdy = '0;
        recv_sub = '0;

        // Multicast: receivers 0, 2, 7 on sender 1
        sub(0, 1); sub(2, 1); sub(7, 1);
        send(1, 128'h11);
        cyc();
        send_en = '0;
        check("t2_recv_en", W'(recv_en), W'(8'b1000_0101));
        recv_rdy = 8'b1000_0101;
        cyc();
        recv_rdy = '0;
        recv_sub = '0;

        // Backpressure: receiver 0 on sender 2 filled to D
        sub(0, 2);
        for (int k = 0; k < D; k++) begin
            send(2, 128'h300 + 128'(k));
            cyc();
        end
        send(2, 128'h3FF);
        recv_rdy[0] = 1'b1;
        #1;
        check("t3_full_rdy", W'(send_rdy[2]), '0);
        cyc();
        send_en = '0;
        recv_rdy = '0;
        check("t3_rdy_after_pop", W'(send_rdy[2]), 128'h1);
        recv_rdy[0] = 1'b1;
        repeat (D - 1) cyc();
        recv_rdy = '0;
        recv_sub = '0;

        // Multicast stall: receiver 1 full, receiver 4 empty, both on sender 0
        sub(1, 0);
        for (int k = 0; k < D; k++) begin
            send(0, 128'h400 + 128'(k));
            cyc();
        end
        sub(4, 0);
        send(0, 128'h4AA);
        cyc();
        check("t4_stall_rdy",  W'(send_rdy[0]), '0);
        check("t4_rx4_level",  W'(recv_level[4*L +: L]), '0);
        recv_rdy[1] = 1'b1;
        cyc();
        recv_rdy = '0;
        cyc();
        send_en = '0;
        check("t4_rx4_after", W'(recv_level[4*L +: L]), 128'h1);
        recv_rdy[1] = 1'b1;
        recv_rdy[4] = 1'b1;
        repeat (D) cyc();
        recv_rdy = '0;
        recv_sub = '0;

        // Streaming with concurrent push/pop, pointer wrap, and mid-stream reselection
        sub(6, 3);
        recv_rdy[6] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                send_en = '0;
                sub(6, 4);
            end
            send((k < 10) ? 3 : 4, 128'h500 + 128'(k));
            cyc();
            check("t5_level_le1", W'(recv_level[6*L +: L] <= 1), 128'h1);
        end
        send_en = '0;
        cyc();
        recv_rdy = '0;
        recv_sub = '0;

        // Dropped word with no subscriber, then asynchronous reset mid-cycle
        sub(2, 1);
        send(1, 128'h600);
        cyc();
        send(1, 128'h601);
        cyc();
        send_en  = '0;
        recv_sub = '0;
        send(3, 128'h6DD);
        cyc();
        send_en = '0;
        check("t6_rx2_level", W'(recv_level[2*L +: L]), 128'h2);
        #2;
        clr_n = 1'b0;
        #1;
        check("t6_rst_recv_en",    W'(recv_en),    '0);
        check("t6_rst_recv_level", W'(recv_level), '0);
        check("t6_rst_recv_word2", recv_word[2*W +: W], '0);
        sb.delete();
        #2;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
